// File: rtl/am_demod_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// am_demod_pkg : widths and helpers shared by the AM demodulator stages.
// Revision 1.0
// ---------------------------------------------------------------------------
package am_demod_pkg;

    localparam int MAG_W   = 16;
    localparam int AUDIO_W = 16;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int                 width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi)      return hi;
        else if (value < lo) return lo;
        else                 return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/am_dc_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// am_dc_tracker : leaky-integrator estimate of the envelope DC level.
// Revision 1.0
// ---------------------------------------------------------------------------
module am_dc_tracker
    import am_demod_pkg::*;
#(
    parameter int IN_W     = MAG_W,
    parameter int DC_SHIFT = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    output logic [IN_W-1:0] dc_est
);

    localparam int c_ACC_W = IN_W + DC_SHIFT;

    logic [c_ACC_W-1:0] r_dc_acc;

    // Estimate is the value before this sample's update; acc never exceeds 2^k*(2^IN_W-1).
    assign dc_est = r_dc_acc[c_ACC_W-1:DC_SHIFT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dc_acc <= '0;
        end else if (in_valid) begin
            r_dc_acc <= r_dc_acc + {{DC_SHIFT{1'b0}}, in_data} - {{DC_SHIFT{1'b0}}, dc_est};
        end
    end

endmodule
`default_nettype wire

// File: rtl/am_dc_decim.sv
`default_nettype none
// ---------------------------------------------------------------------------
// am_dc_decim : DC removal, boxcar decimation and valid/ready audio output.
// Revision 1.0
// ---------------------------------------------------------------------------
module am_dc_decim
    import am_demod_pkg::*;
#(
    parameter int IN_W     = MAG_W,
    parameter int OUT_W    = AUDIO_W,
    parameter int DECIM    = 8,
    parameter int DC_SHIFT = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sat_flag,
    output logic             ovr_flag,
    input  logic             clr_flags
);

    localparam int c_LOG2D = clog2(DECIM);
    localparam int c_ACC_W = IN_W + 1 + c_LOG2D;
    localparam int c_CNT_W = (c_LOG2D < 1) ? 1 : c_LOG2D;

    logic [IN_W-1:0]           w_dc_est;
    logic signed [IN_W:0]      w_diff;
    logic signed [c_ACC_W-1:0] w_sum;
    logic signed [c_ACC_W-1:0] w_res;
    logic signed [63:0]        w_sat;
    logic                      w_clip;
    logic                      w_dump;
    logic                      w_load;
    logic                      w_ovr_set;
    logic                      w_sat_set;

    logic signed [c_ACC_W-1:0] r_acc;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [OUT_W-1:0]          r_out_data;
    logic                      r_out_valid;
    logic                      r_sat_flag;
    logic                      r_ovr_flag;

    am_dc_tracker #(
        .IN_W     (IN_W),
        .DC_SHIFT (DC_SHIFT)
    ) u_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .dc_est   (w_dc_est)
    );

    assign w_diff    = $signed({1'b0, in_data}) - $signed({1'b0, w_dc_est});
    assign w_sum     = r_acc + {{c_LOG2D{w_diff[IN_W]}}, w_diff};
    assign w_res     = w_sum >>> c_LOG2D;
    assign w_sat     = sat_signed(64'(w_res), OUT_W);
    assign w_clip    = (w_sat != 64'(w_res));
    assign w_dump    = in_valid && (r_cnt == c_CNT_W'(DECIM - 1));
    // A pending sample blocks the new result unless it is consumed this same cycle.
    assign w_load    = w_dump && (!r_out_valid || out_ready);
    assign w_ovr_set = w_dump && r_out_valid && !out_ready;
    assign w_sat_set = w_dump && w_clip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (in_valid) begin
            if (w_dump) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_sat[OUT_W-1:0];
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_flag <= 1'b0;
            r_ovr_flag <= 1'b0;
        end else begin
            r_sat_flag <= w_sat_set || (r_sat_flag && !clr_flags);
            r_ovr_flag <= w_ovr_set || (r_ovr_flag && !clr_flags);
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign sat_flag  = r_sat_flag;
    assign ovr_flag  = r_ovr_flag;

endmodule
`default_nettype wire

// File: tb/tb_am_dc_decim.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_am_dc_decim : directed bench for am_dc_decim (DECIM=8, DC_SHIFT=4).
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_am_dc_decim;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sat_flag;
    logic        ovr_flag;
    logic        clr_flags;

    int n_vec;
    int n_err;

    // Reference state
    longint      m_dc;
    longint      m_acc;
    int          m_cnt;
    logic        m_valid;
    logic        m_sat;
    logic        m_ovr;
    logic [15:0] m_data;
    bit          m_dump;

    am_dc_decim #(
        .IN_W     (16),
        .OUT_W    (16),
        .DECIM    (8),
        .DC_SHIFT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag),
        .ovr_flag  (ovr_flag),
        .clr_flags (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".out_data"},  32'(out_data),  32'(m_data));
        chk({tag, ".sat_flag"},  32'(sat_flag),  32'(m_sat));
        chk({tag, ".ovr_flag"},  32'(ovr_flag),  32'(m_ovr));
    endtask

    task automatic model_reset();
        m_dc = 0; m_acc = 0; m_cnt = 0;
        m_valid = 1'b0; m_sat = 1'b0; m_ovr = 1'b0; m_data = '0; m_dump = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [15:0] d, input logic rdy, input logic clr);
        bit     dump, sset, oset;
        longint est, diff, res;
        dump = 0; sset = 0; oset = 0; res = 0;
        if (v) begin
            est  = m_dc >> 4;
            diff = longint'(d) - est;
            m_dc = m_dc + longint'(d) - est;
            if (m_cnt == 7) begin
                res   = (m_acc + diff) >>> 3;
                m_acc = 0;
                m_cnt = 0;
                dump  = 1;
                if (res > 32767) begin
                    res = 32767; sset = 1;
                end else if (res < -32768) begin
                    res = -32768; sset = 1;
                end
            end else begin
                m_acc = m_acc + diff;
                m_cnt = m_cnt + 1;
            end
        end
        if (dump) begin
            if (!m_valid || rdy) begin
                m_data  = res[15:0];
                m_valid = 1'b1;
            end else begin
                oset = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (clr) begin
            m_sat = 1'b0; m_ovr = 1'b0;
        end
        if (sset) m_sat = 1'b1;
        if (oset) m_ovr = 1'b1;
        m_dump = dump;
    endtask

    // Called #1 after a rising edge: drive, clock, update model, check.
    task automatic cycle(input logic v, input logic [15:0] d, input logic rdy, input logic clr);
        in_valid = v; in_data = d; out_ready = rdy; clr_flags = clr;
        @(posedge clk);
        model_edge(v, d, rdy, clr);
        #1;
        check_all("cyc");
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_flags = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_all("reset");
    endtask

    initial begin
        int          prev;
        int          v;
        int          n_out;
        logic [15:0] first_res;

        n_vec = 0; n_err = 0;
        rst_n = 1'b1;
        model_reset();
        #2;
        do_reset();
        chk("reset_data_zero", 32'(out_data), 32'd0);

        // Reset mid-run: partial boxcar of 100s must be thrown away
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'd100, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, 16'd0, 1'b0, 1'b0);
        chk("midrst_no_early_valid", 32'(out_valid), 32'd0);
        cycle(1'b1, 16'd0, 1'b0, 1'b0);
        chk("midrst_valid", 32'(out_valid), 32'd1);
        chk("midrst_data",  32'(out_data),  32'd0);
        chk("midrst_flags", 32'({sat_flag, ovr_flag}), 32'd0);
        cycle(1'b0, 16'd0, 1'b1, 1'b0);
        chk("midrst_release", 32'(out_valid), 32'd0);

        // Step response to 1000: first output 6455>>>3 = 806
        do_reset();
        prev = 32767; n_out = 0; v = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(1'b1, 16'd1000, 1'b1, 1'b0);
            if (m_dump) begin
                v = int'($signed(out_data));
                if (n_out == 0) chk("step_first", 32'(v), 32'd806);
                chk("step_monotonic", 32'(v <= prev), 32'd1);
                prev = v;
                n_out++;
            end
        end
        chk("step_count", 32'(n_out), 32'd50);
        chk("step_final", 32'(v >= -1 && v <= 0), 32'd1);
        chk("step_no_sat", 32'(sat_flag), 32'd0);

        // Saturation: average diff of 65535s is 52858, clipped to 32767
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
        chk("sat_data", 32'(out_data), 32'd32767);
        chk("sat_flag_set", 32'(sat_flag), 32'd1);
        cycle(1'b0, 16'd0, 1'b1, 1'b1);
        chk("sat_flag_clr", 32'(sat_flag), 32'd0);

        // Overrun: two dumps with out_ready low
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'd500, 1'b0, 1'b0);
        first_res = out_data;
        chk("ovr_first_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'd3000, 1'b0, 1'b0);
        chk("ovr_data_kept", 32'(out_data), 32'(first_res));
        chk("ovr_flag_set", 32'(ovr_flag), 32'd1);
        chk("ovr_valid_held", 32'(out_valid), 32'd1);
        cycle(1'b0, 16'd0, 1'b1, 1'b0);
        chk("ovr_one_consumed", 32'(out_valid), 32'd0);
        cycle(1'b0, 16'd0, 1'b1, 1'b1);
        chk("ovr_flag_clr", 32'(ovr_flag), 32'd0);

        // Same-cycle dump and handshake
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'd200, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 16'd4000, 1'b0, 1'b0);
        cycle(1'b1, 16'd4000, 1'b1, 1'b0);
        chk("same_valid", 32'(out_valid), 32'd1);
        chk("same_no_ovr", 32'(ovr_flag), 32'd0);
        chk("same_new_data", 32'(out_data != first_res), 32'd1);

        // Random gaps with toggling out_ready, then out_ready held high
        do_reset();
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
        cycle(1'b0, 16'd0, 1'b1, 1'b1);
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 16'($urandom_range(0, 40000)), 1'b1, 1'b0);
        chk("ready_high_no_drop", 32'(ovr_flag), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/am_dc_decim.md
# am_dc_decim

Post-demodulation audio stage of the AM receive chain. It consumes the unsigned envelope magnitude produced by the square-root stage, one sample per `in_valid` strobe, and removes the carrier-induced DC level with a leaky-integrator tracker. It then boxcar-averages and decimates by `DECIM` and delivers signed audio samples to the downstream audio/PWM path through a valid/ready output register.

## Interface
- `IN_W`, 16: width of the unsigned magnitude input.
- `OUT_W`, 16: width of the signed audio output.
- `DECIM`, 8: decimation factor; power of two, 2..256.
- `DC_SHIFT`, 10: DC tracker time constant k; tracker gain is 2^-k, legal range 2..16.

Clocking and reset are fixed: one clock; reset is asynchronous and active-low.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  IN_W  unsigned envelope magnitude.
- `in_valid`  in  1  sample strobe; no backpressure, every strobe is accepted.
- `out_data`  out  OUT_W  signed decimated audio.
- `out_valid`  out  1  `out_data` holds an unconsumed sample.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.
- `sat_flag`  out  1  sticky: an output was clipped.
- `ovr_flag`  out  1  sticky: a decimated result was dropped.
- `clr_flags`  in  1  synchronous clear of both sticky flags.

## Operation
- **DC tracker, per accepted sample:**
  - `dc_acc` is unsigned, IN_W+DC_SHIFT bits.
  - Update: `dc_acc <= dc_acc + in_data - (dc_acc >> DC_SHIFT)`.
  - `dc_est = dc_acc >> DC_SHIFT`. The recurrence cannot overflow.
- **Difference:** `diff = {0,in_data} - {0,dc_est}`, signed IN_W+1 bits. It uses `dc_est` from before this sample's update.
- **Boxcar:**
  - `acc` is signed, IN_W+1+log2(DECIM) bits.
  - `cnt` runs 0..DECIM-1 and increments per accepted sample.
  - When `cnt != DECIM-1`: `acc <= acc + diff`.
  - When `cnt == DECIM-1` (dump): `sum = acc + diff`, `acc <= 0`, `cnt <= 0`.
- **Scaling at dump:**
  - `res = sum >>> log2(DECIM)`, arithmetic shift, truncation toward −∞.
  - `res` is saturated to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - Any clip sets `sat_flag`.
- **Output register, at a dump:**
  - If `!out_valid` or `out_ready`: `out_data <= res`, `out_valid <= 1`.
  - Otherwise (`out_valid && !out_ready`): `res` is discarded, `out_data` is unchanged and `ovr_flag` is set.
- **Release:** when `out_valid && out_ready` and there is no dump in the same cycle, `out_valid <= 0`.
- **Sticky flags:**
  - `clr_flags` clears both flags.
  - If a set event and `clr_flags` occur in the same cycle, the set wins.
- **No input (`in_valid` = 0):** `dc_acc`, `acc` and `cnt` hold.

## Timing
- **Reset values:** `out_data` = 0, `out_valid` = 0, `sat_flag` = 0, `ovr_flag` = 0. `dc_acc`, `acc` and `cnt` are also 0.
- **Reset mid-operation:** a partial boxcar is discarded. The first output after reset is built from the next DECIM samples.
- **Latency:** a dump on the clock edge that accepts sample n (`cnt == DECIM-1`) makes `out_valid` = 1 and the new `out_data` visible right after that edge. This is one register stage.
- **Throughput:** `in_valid` may be high every cycle, which gives one output per DECIM cycles.
- **Same-cycle dump and handshake:** a dump in the same cycle as `out_valid && out_ready` loads the new value with `out_valid` staying 1. This is not an overrun.
- **`out_valid` stability:** `out_valid` never drops without a handshake. `out_data` is stable while `out_valid && !out_ready`.

## Structure
- **Shared package `am_demod_pkg`:**
  - constants `MAG_W` (16) and `AUDIO_W` (16), shared with the sqrt stage;
  - function `sat_signed(value, width)`;
  - function `clog2`.
- **One sub-module, `am_dc_tracker`:**
  - holds the `dc_acc` register;
  - inputs `clk`, `rst_n`, `in_data`, `in_valid`;
  - output `dc_est` (pre-update value);
  - parameters IN_W and DC_SHIFT.
- **Top level:** boxcar, counter, saturation, output register and flags.

## Test plan
- **Reset mid-run:** with DECIM=8, DC_SHIFT=4, feed 5 samples of 100, assert `rst_n` low for 1 cycle, then apply 8 samples of 0 → single output 0, `out_valid` pulse after the 8th sample, flags 0.
- **Step response:** with DECIM=8, DC_SHIFT=4 and `out_ready` held at 1, apply constant `in_data` = 1000 every cycle from reset → first output positive and ≤ 1000. Outputs decay monotonically and are within [−1, 0] after 400 samples. `sat_flag` stays 0.
- **Saturation:** with defaults, apply constant 65535 from reset → first output is 32767 and `sat_flag` = 1. `clr_flags` pulse → `sat_flag` = 0 on the next cycle.
- **Overrun:** hold `out_ready` = 0 across two dumps → `out_data` keeps the first result, `ovr_flag` = 1, `out_valid` stays 1. A later `out_ready` pulse consumes exactly one sample.
- **Back-to-back with gaps:** with random `in_valid` gaps (about 50%) and `out_ready` toggling, compare against a bit-exact reference model of the tracker, boxcar and saturation → all outputs match. No drops occur while `out_ready` is 1 at every dump.
- **Same-cycle handshake:** a dump coincides with `out_valid && out_ready` → new value loaded, `out_valid` stays 1, `ovr_flag` stays 0.
